// File: rtl/dout_par_tx_if.sv
// Core-side write port and peripheral-side parallel bus of dout_par_tx.
// Optional dout_par signal present only when DOUT_PARITY_EN is defined.
interface dout_par_tx_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic [WIDTH-1:0] dout;
  logic             stb;
  logic             ack;
  logic             busy;
`ifdef DOUT_PARITY_EN
  logic             dout_par;
`endif

  // core + peripheral side (drives writes and ack)
  modport master (
    output wr_en, wr_data, ack,
    input  full, empty, level, dout, stb, busy
`ifdef DOUT_PARITY_EN
    , input dout_par
`endif
  );

  // transmitter side
  modport slave (
    input  wr_en, wr_data, ack,
    output full, empty, level, dout, stb, busy
`ifdef DOUT_PARITY_EN
    , output dout_par
`endif
  );
endinterface

// File: rtl/dout_par_tx.sv
// Parallel-bus transmitter: small FIFO from the core, four-phase
// stb/ack handshake per byte with a programmable data setup time.
// Optional feature macro: DOUT_PARITY_EN adds registered even parity of dout.
module dout_par_tx #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2
)(
  input logic          clk,
  input logic          rst,
  dout_par_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full, r_empty;
  logic             r_ack_s1, r_ack_s2;
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_stb;
`ifdef DOUT_PARITY_EN
  logic             r_dout_par;
`endif

  logic             w_pop, w_push;
  logic [LW-1:0]    w_level_nxt;
  logic [WIDTH-1:0] w_head;

  assign w_head = r_mem[r_rd_ptr];

  // pop on IDLE with data, or on HOLD once the peripheral released ack
  always_comb begin
    w_pop = 1'b0;
    if (!r_empty) begin
      if (r_state == S_IDLE)                w_pop = 1'b1;
      if (r_state == S_HOLD && !r_ack_s2)   w_pop = 1'b1;
    end
    // a simultaneous pop frees a slot, so a write while full still lands
    w_push = bus.wr_en && (!r_full || w_pop);
  end

  // next occupancy; push+pop leaves it unchanged
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_nxt = r_level - 1'b1;
  end

  // two-flop synchroniser for the asynchronous ack pin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
    end else begin
      r_ack_s1 <= bus.ack;
      r_ack_s2 <= r_ack_s1;
    end
  end

  // storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  // pointers and registered status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // handshake FSM; dout only moves on a pop edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_stb   <= 1'b0;
`ifdef DOUT_PARITY_EN
      r_dout_par <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE:   if (!r_empty) r_state <= S_SETUP;
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_STROBE;
            r_stb   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STROBE: begin
          if (r_ack_s2) begin
            r_state <= S_HOLD;
            r_stb   <= 1'b0;
          end
        end
        S_HOLD:   if (!r_ack_s2) r_state <= r_empty ? S_IDLE : S_SETUP;
        default:  r_state <= S_IDLE;
      endcase
      if (w_pop) begin
        r_dout <= w_head;
        r_cnt  <= CW'(SETUP_CYC - 1);
`ifdef DOUT_PARITY_EN
        r_dout_par <= ^w_head;
`endif
      end
    end
  end

  assign bus.full  = r_full;
  assign bus.empty = r_empty;
  assign bus.level = r_level;
  assign bus.dout  = r_dout;
  assign bus.stb   = r_stb;
  assign bus.busy  = (r_state != S_IDLE);
`ifdef DOUT_PARITY_EN
  assign bus.dout_par = r_dout_par;
`endif
endmodule

// File: tb/tb_dout_par_tx.sv
// Bench for dout_par_tx: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dout_par_tx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SETUP_CYC = 2;

  localparam int P_IDLE = 0, P_SETUP = 1, P_STROBE = 2, P_HOLD = 3;

  logic clk;
  logic rst;
  dout_par_tx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dout_par_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  logic [7:0] mq[$];
  int         m_phase = P_IDLE;
  int         m_cnt   = 0;
  logic [7:0] m_dout  = '0;
  logic       m_stb   = 1'b0;
  logic       m_a1    = 1'b0;
  logic       m_a2    = 1'b0;

  // stimulus / observation
  int         ack_mode = 0;     // 0 manual, 1 follows stb one cycle late, 2 random
  logic       ack_man  = 1'b0;
  logic [7:0] rx[$];
  logic       rxp[$];
  int         t_stb  = 0;
  int         t_dout = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model: byte queue plus handshake timeline, stepped on each clock edge
  initial begin
    logic       pop, wr, ackp, full_now;
    logic [7:0] wd;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_phase = P_IDLE; m_cnt = 0; m_dout = '0; m_stb = 1'b0;
        m_a1 = 1'b0; m_a2 = 1'b0;
      end else begin
        pop = 1'b0; wr = bus.wr_en; wd = bus.wr_data; ackp = bus.ack;
        case (m_phase)
          P_IDLE:   if (mq.size() != 0) pop = 1'b1;
          P_SETUP:  if (m_cnt == 0) begin m_phase = P_STROBE; m_stb = 1'b1; end
                    else m_cnt--;
          P_STROBE: if (m_a2) begin m_phase = P_HOLD; m_stb = 1'b0; end
          default:  if (!m_a2) begin
                      if (mq.size() != 0) pop = 1'b1;
                      else m_phase = P_IDLE;
                    end
        endcase
        full_now = (mq.size() == DEPTH);
        if (pop) begin
          m_dout  = mq.pop_front();
          m_phase = P_SETUP;
          m_cnt   = SETUP_CYC - 1;
        end
        if (wr && (!full_now || pop)) mq.push_back(wd);
        m_a2 = m_a1;
        m_a1 = ackp;
      end
    end
  end

  // compare on falling edge, record bus activity, drive the peripheral ack
  initial begin
    logic       prev_stb  = 1'b0;
    logic [7:0] prev_dout = '0;
    bus.ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      chk("dout",  int'(bus.dout),  int'(m_dout));
      chk("stb",   int'(bus.stb),   int'(m_stb));
      chk("busy",  int'(bus.busy),  int'(m_phase != P_IDLE));
      chk("full",  int'(bus.full),  int'(mq.size() == DEPTH));
      chk("empty", int'(bus.empty), int'(mq.size() == 0));
      chk("level", int'(bus.level), mq.size());
`ifdef DOUT_PARITY_EN
      chk("dout_par", int'(bus.dout_par), int'(^m_dout));
`endif
      if (bus.stb && !prev_stb) begin
        rx.push_back(bus.dout);
        t_stb = cyc;
`ifdef DOUT_PARITY_EN
        rxp.push_back(bus.dout_par);
`endif
      end
      if (bus.dout != prev_dout) t_dout = cyc;
      case (ack_mode)
        0:       bus.ack = ack_man;
        1:       bus.ack = prev_stb;
        default: if ($urandom_range(0, 3) == 0) bus.ack = ~bus.ack;
      endcase
      prev_stb  = bus.stb;
      prev_dout = bus.dout;
    end
  end

  task automatic wr(input logic [7:0] d);
    @(negedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_data = d;
  endtask

  task automatic wr_off();
    @(negedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk); #1;
      if (!bus.busy && bus.empty) done = 1'b1;
    end
    chk(nm, int'(done), 1);
  endtask

  task automatic wait_stb(input string nm, input logic v, input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk); #1;
      if (bus.stb == v) done = 1'b1;
    end
    chk(nm, int'(done), 1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    #1 rst = 1'b0;

    // 1: reset state, then idle with no writes
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_stb", int'(bus.stb), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_level", int'(bus.level), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("idle_dout", int'(bus.dout), 0);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_empty", int'(bus.empty), 1);

    // 2: single byte, ack follows stb one cycle late
    ack_mode = 1;
    rx.delete();
    wr(8'hA5);
    k = cyc;
    wr_off();
    wait_idle("t2_idle", 60);
    chk("t2_setup_gap", t_stb - t_dout, SETUP_CYC);
    chk("t2_stb_latency", t_stb - k, 2 + SETUP_CYC);
    chk("t2_rx_cnt", rx.size(), 1);
    chk("t2_rx0", int'(rx[0]), 8'hA5);

    // 3: fill with ack low; first byte already sits on the bus
    ack_mode = 0; ack_man = 1'b0;
    rx.delete();
    for (int d = 1; d <= 6; d++) begin
      @(negedge clk); #1;
      if (d == 5) chk("t3_level_after4", int'(bus.level), 3);
      if (d == 6) begin
        chk("t3_full", int'(bus.full), 1);
        chk("t3_level_full", int'(bus.level), DEPTH);
      end
      bus.wr_en = 1'b1; bus.wr_data = 8'(d);
    end
    wr_off();
    chk("t3_drop_level", int'(bus.level), DEPTH);
    ack_mode = 1;
    wait_idle("t3_idle", 300);
    chk("t3_rx_cnt", rx.size(), 5);
    for (int i = 0; i < 5 && i < rx.size(); i++)
      chk("t3_rx_order", int'(rx[i]), i + 1);

    // 4: write while full on the HOLD->SETUP pop edge
    ack_mode = 0; ack_man = 1'b0;
    rx.delete();
    for (int d = 0; d < 5; d++) wr(8'h11 + 8'(d));
    wr_off();
    chk("t4_full", int'(bus.full), 1);
    wait_stb("t4_stb_hi", 1'b1, 40);
    ack_man = 1'b1;
    wait_stb("t4_stb_lo", 1'b0, 40);
    ack_man = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    bus.wr_en = 1'b1; bus.wr_data = 8'h16;
    @(negedge clk); #1;
    bus.wr_en = 1'b0;
    chk("t4_level", int'(bus.level), DEPTH);
    chk("t4_full_after", int'(bus.full), 1);
    chk("t4_dout_next", int'(bus.dout), 8'h12);
    ack_mode = 1;
    wait_idle("t4_idle", 300);
    chk("t4_rx_cnt", rx.size(), 6);
    if (rx.size() == 6) chk("t4_rx_last", int'(rx[5]), 8'h16);

    // 5: reset in the middle of STROBE with three bytes queued
    ack_mode = 0; ack_man = 1'b0;
    for (int d = 0; d < 4; d++) wr(8'h21 + 8'(d));
    wr_off();
    wait_stb("t5_stb_hi", 1'b1, 40);
    chk("t5_level", int'(bus.level), 3);
    rst = 1'b0;
    #1;
    chk("t5_stb", int'(bus.stb), 0);
    chk("t5_dout", int'(bus.dout), 0);
    chk("t5_empty", int'(bus.empty), 1);
    chk("t5_level0", int'(bus.level), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    rx.delete();
    ack_mode = 1;
    repeat (30) @(negedge clk);
    chk("t5_no_stale", rx.size(), 0);

`ifdef DOUT_PARITY_EN
    // 6: parity follows the byte on the bus
    rx.delete(); rxp.delete();
    wr(8'h07);
    wr(8'h03);
    wr_off();
    wait_idle("t6_idle", 100);
    chk("t6_cnt", rxp.size(), 2);
    if (rxp.size() == 2) begin
      chk("t6_par0", int'(rxp[0]), 1);
      chk("t6_par1", int'(rxp[1]), 0);
    end
`endif

    // random traffic with a randomly toggling ack
    ack_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_data = 8'($urandom);
    end
    bus.wr_en = 1'b0;
    ack_mode = 1;
    wait_idle("rand_drain", 400);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
